zigzag_dequant: RTL and testbench
=================================

// Module: zigzag_dequant
// PURPOSE
//  Upstream feeder for the 8x8 IDCT top. Accepts a serial stream of 64 quantized
//  coefficients per block in JPEG zigzag order. Multiplies each by its quantization
//  table entry and scatters it into natural order x[row][col] (row = vertical freq).
//  Presents the finished 8x8 matrix to the IDCT with a one-cycle start pulse, then
//  holds the matrix stable until the IDCT reports done.
// PARAMETERS
//  COEF_W  12  width of signed input coefficient
//  Q_W     8   width of unsigned quant table entry
//  OUT_W   16  width of signed dequantized output (matches IDCT x input)
// PORTS
//  sys_clk     in   1            clock; all logic rising-edge
//  sys_rst     in   1            synchronous reset, active-low
//  in_valid    in   1            coefficient valid
//  in_ready    out  1            coefficient accepted when in_valid && in_ready
//  in_coef     in   COEF_W       signed quantized coefficient, zigzag order
//  q_wr_en     in   1            quant table write strobe
//  q_wr_addr   in   6            table index, zigzag order (0..63)
//  q_wr_data   in   Q_W          unsigned quant value
//  x           out  8x8xOUT_W    signed dequantized matrix to IDCT, x[row][col]
//  start       out  1            one-cycle pulse: matrix ready, start IDCT
//  idct_done   in   1            IDCT done (level or pulse)
//  sat_flag    out  1            sticky per block: a product was clipped
// BEHAVIOUR
//  Reset (sys_rst==0 at edge):
//  - state=FILL, k=0; all x=0; start=0; sat_flag=0; done_q=0.
//  - All 64 q entries=1 (identity).
//  - in_ready forced 0 while sys_rst is low.
//  FSM states and transitions:
//  - FILL: in_ready=1. Each accept writes x[zz_row(k)][zz_col(k)] at the next edge,
//    then k++. Accept at k==63 -> ISSUE, k wraps to 0.
//  - ISSUE: in_ready=0, start=1 for exactly this cycle -> WAIT.
//  - WAIT: in_ready=0, start=0. Rising edge of idct_done (idct_done && !done_q) -> FILL.
//    idct_done is ignored in FILL and ISSUE.
//  - done_q is idct_done registered every cycle, so done held high from a prior
//    block cannot retrigger.
//  Timing:
//  - Last accept in cycle N: start=1 in N+1, WAIT from N+2.
//  - Done edge in cycle M: in_ready=1 in M+1.
//  Arithmetic:
//  - p = signed(in_coef) * unsigned(q[k]), full COEF_W+Q_W+1 bits.
//  - Result clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//  sat_flag:
//  - Accept at k==0 loads sat_flag with that coefficient's clip status.
//  - Other accepts OR their clip status into sat_flag.
//  Matrix hold:
//  - x changes only on accepts; it is stable from ISSUE through WAIT.
//  - The next block overwrites all 64 entries, so there is no clearing between blocks.
//  Zigzag map: standard JPEG. k=1->(0,1), 2->(1,0), 3->(2,0), 5->(0,2),
//    28->(0,7), 35->(7,0), 63->(7,7).
//  Quant table:
//  - Writes are allowed in any state.
//  - An accept in the same cycle as a write to the same index uses the old value.
//  - q=0 yields 0.
//  - Reset mid-block discards the partial block and returns to the reset state.
// TESTING
//  T1 DC: q=identity; k0=1024, then 63 zeros -> x[0][0]=1024, others 0;
//     start high one cycle, exactly 1 cycle after the 64th accept; in_ready=0 after.
//  T2 order: coef=k+1 for k=0..63, q=1 -> x[0][1]=2, x[1][0]=3, x[2][0]=4,
//     x[0][7]=29, x[7][0]=36, x[7][7]=64.
//  T3 dequant: write q[0]=16, q[4]=3; k0=-5, k4=7 -> x[0][0]=-80, x[1][1]=21,
//     sat_flag=0.
//  T4 clip: q[0]=255, k0=2047 -> x[0][0]=32767, sat_flag=1. Next block,
//     k0=-2048 -> x[0][0]=-32768, sat_flag=1. Following block without clip -> 0.
//  T5 handshake: random in_valid gaps; idct_done held high across ISSUE, then low
//     20 cycles -> in_ready=0 and x unchanged; done rises -> in_ready=1 next cycle.
//  T6 reset mid-block after 30 accepts -> x all 0, k=0. A clean 64-coef block then
//     completes normally with a single start pulse.

Source files
------------

// File: rtl/zigzag_dequant.sv
// zigzag_dequant: collects 64 zigzag-ordered quantized coefficients, dequantizes
// each against a writable quant table, scatters them into natural row/col order
// and hands the finished 8x8 matrix to the IDCT with a single start pulse.
module zigzag_dequant #(
  parameter int COEF_W = 12,
  parameter int Q_W    = 8,
  parameter int OUT_W  = 16
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_coef,
  input  logic                     q_wr_en,
  input  logic [5:0]               q_wr_addr,
  input  logic [Q_W-1:0]           q_wr_data,
  output logic signed [OUT_W-1:0]  x [0:7][0:7],
  output logic                     start,
  input  logic                     idct_done,
  output logic                     sat_flag
);

  // Full product width: signed coefficient times unsigned quant value
  localparam int PROD_W = COEF_W + Q_W + 1;

  localparam logic signed [PROD_W-1:0] MAX_P = {{(PROD_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] MIN_P = {{(PROD_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic [5:0]                k;
  logic                      done_q;
  logic [Q_W-1:0]            q [0:63];
  logic                      accept;
  logic [5:0]                nat;
  logic signed [PROD_W-1:0]  coef_ext;
  logic signed [PROD_W-1:0]  q_ext;
  logic signed [PROD_W-1:0]  prod;
  logic                      clip;
  logic signed [OUT_W-1:0]   val;

  // JPEG zigzag position -> natural index (row*8 + col)
  function automatic logic [5:0] zz_nat(input logic [5:0] idx);
    zz_nat = 6'd0;
    case (idx)
      6'd0:  zz_nat = 6'd0;
      6'd1:  zz_nat = 6'd1;
      6'd2:  zz_nat = 6'd8;
      6'd3:  zz_nat = 6'd16;
      6'd4:  zz_nat = 6'd9;
      6'd5:  zz_nat = 6'd2;
      6'd6:  zz_nat = 6'd3;
      6'd7:  zz_nat = 6'd10;
      6'd8:  zz_nat = 6'd17;
      6'd9:  zz_nat = 6'd24;
      6'd10: zz_nat = 6'd32;
      6'd11: zz_nat = 6'd25;
      6'd12: zz_nat = 6'd18;
      6'd13: zz_nat = 6'd11;
      6'd14: zz_nat = 6'd4;
      6'd15: zz_nat = 6'd5;
      6'd16: zz_nat = 6'd12;
      6'd17: zz_nat = 6'd19;
      6'd18: zz_nat = 6'd26;
      6'd19: zz_nat = 6'd33;
      6'd20: zz_nat = 6'd40;
      6'd21: zz_nat = 6'd48;
      6'd22: zz_nat = 6'd41;
      6'd23: zz_nat = 6'd34;
      6'd24: zz_nat = 6'd27;
      6'd25: zz_nat = 6'd20;
      6'd26: zz_nat = 6'd13;
      6'd27: zz_nat = 6'd6;
      6'd28: zz_nat = 6'd7;
      6'd29: zz_nat = 6'd14;
      6'd30: zz_nat = 6'd21;
      6'd31: zz_nat = 6'd28;
      6'd32: zz_nat = 6'd35;
      6'd33: zz_nat = 6'd42;
      6'd34: zz_nat = 6'd49;
      6'd35: zz_nat = 6'd56;
      6'd36: zz_nat = 6'd57;
      6'd37: zz_nat = 6'd50;
      6'd38: zz_nat = 6'd43;
      6'd39: zz_nat = 6'd36;
      6'd40: zz_nat = 6'd29;
      6'd41: zz_nat = 6'd22;
      6'd42: zz_nat = 6'd15;
      6'd43: zz_nat = 6'd23;
      6'd44: zz_nat = 6'd30;
      6'd45: zz_nat = 6'd37;
      6'd46: zz_nat = 6'd44;
      6'd47: zz_nat = 6'd51;
      6'd48: zz_nat = 6'd58;
      6'd49: zz_nat = 6'd59;
      6'd50: zz_nat = 6'd52;
      6'd51: zz_nat = 6'd45;
      6'd52: zz_nat = 6'd38;
      6'd53: zz_nat = 6'd31;
      6'd54: zz_nat = 6'd39;
      6'd55: zz_nat = 6'd46;
      6'd56: zz_nat = 6'd53;
      6'd57: zz_nat = 6'd60;
      6'd58: zz_nat = 6'd61;
      6'd59: zz_nat = 6'd54;
      6'd60: zz_nat = 6'd47;
      6'd61: zz_nat = 6'd55;
      6'd62: zz_nat = 6'd62;
      6'd63: zz_nat = 6'd63;
    endcase
  endfunction

  // True when the product does not fit the signed output range
  function automatic logic is_clip(input logic signed [PROD_W-1:0] p);
    return (p > MAX_P) || (p < MIN_P);
  endfunction

  // Saturate the product into the signed output range
  function automatic logic signed [OUT_W-1:0] sat_clip(input logic signed [PROD_W-1:0] p);
    logic signed [OUT_W-1:0] r;
    if (p > MAX_P) begin
      r = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (p < MIN_P) begin
      r = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      r = p[OUT_W-1:0];
    end
    return r;
  endfunction

  // Control: state sequencing, handshake and start pulse
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    start     = 1'b0;
    case (state)
      FILL: begin
        in_ready = sys_rst;
        if (in_valid && sys_rst && (k == 6'd63)) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        start     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        // Only a fresh rising edge of done releases the matrix
        if (idct_done && !done_q) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Datapath: quant lookup, full-width multiply, saturation and scatter address
  always_comb begin
    accept   = in_valid && in_ready;
    nat      = zz_nat(k);
    coef_ext = $signed({{(Q_W+1){in_coef[COEF_W-1]}}, in_coef});
    q_ext    = $signed({{(COEF_W+1){1'b0}}, q[k]});
    prod     = coef_ext * q_ext;
    clip     = is_clip(prod);
    val      = sat_clip(prod);
  end

  // State register, coefficient index, done edge detector and sticky clip flag
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state    <= FILL;
      k        <= 6'd0;
      done_q   <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= idct_done;
      if (accept) begin
        k        <= k + 6'd1;
        sat_flag <= (k == 6'd0) ? clip : (sat_flag | clip);
      end
    end
  end

  // Quant table; a same-cycle accept has already read the old entry
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      for (int i = 0; i < 64; i++) begin
        q[i] <= {{(Q_W-1){1'b0}}, 1'b1};
      end
    end else if (q_wr_en) begin
      q[q_wr_addr] <= q_wr_data;
    end
  end

  // Output matrix: written only on accepts, so it holds through ISSUE and WAIT
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      for (int r = 0; r < 8; r++) begin
        for (int c = 0; c < 8; c++) begin
          x[r][c] <= '0;
        end
      end
    end else if (accept) begin
      x[nat[5:3]][nat[2:0]] <= val;
    end
  end

endmodule

// File: tb/tb_zigzag_dequant.sv
// Testbench for zigzag_dequant: scoreboard of expected matrices fed by a
// behavioural model, checked by an independent monitor on each start pulse.
module tb_zigzag_dequant;

  localparam int COEF_W = 12;
  localparam int Q_W    = 8;
  localparam int OUT_W  = 16;

  logic                     sys_clk = 1'b0;
  logic                     sys_rst = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [COEF_W-1:0] in_coef = '0;
  logic                     q_wr_en = 1'b0;
  logic [5:0]               q_wr_addr = '0;
  logic [Q_W-1:0]           q_wr_data = '0;
  logic signed [OUT_W-1:0]  x [0:7][0:7];
  logic                     start;
  logic                     idct_done = 1'b0;
  logic                     sat_flag;

  always #5 sys_clk = ~sys_clk;

  zigzag_dequant #(
    .COEF_W(COEF_W),
    .Q_W   (Q_W),
    .OUT_W (OUT_W)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_coef  (in_coef),
    .q_wr_en  (q_wr_en),
    .q_wr_addr(q_wr_addr),
    .q_wr_data(q_wr_data),
    .x        (x),
    .start    (start),
    .idct_done(idct_done),
    .sat_flag (sat_flag)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_starts = 0;
  int blocks_sent = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Reference model state
  int zr[64];
  int zc[64];
  int qm[64];
  int mx[8][8];
  int mk;
  bit msat;
  int blk[64];

  // Scoreboard
  int exp_vals[$];
  bit exp_sat[$];
  int exp_cyc[$];

  task automatic chk(input string nm, input longint act, input longint expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Zigzag order by walking anti-diagonals, alternating direction
  task automatic build_zz();
    int n;
    n = 0;
    for (int s = 0; s < 15; s++) begin
      int lo, hi;
      lo = (s > 7) ? s - 7 : 0;
      hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zr[n] = r; zc[n] = s - r; n++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zr[n] = r; zc[n] = s - r; n++; end
      end
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 64; i++) qm[i] = 1;
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) mx[r][c] = 0;
    mk = 0;
    msat = 0;
  endtask

  task automatic model_accept(input int coef);
    int p;
    bit c;
    p = coef * qm[mk];
    c = 0;
    if (p > 32767) begin p = 32767; c = 1; end
    else if (p < -32768) begin p = -32768; c = 1; end
    mx[zr[mk]][zc[mk]] = p;
    msat = (mk == 0) ? c : (msat | c);
    if (mk == 63) begin
      for (int r = 0; r < 8; r++) for (int cc = 0; cc < 8; cc++) exp_vals.push_back(mx[r][cc]);
      exp_sat.push_back(msat);
      exp_cyc.push_back(cyc + 1);
      blocks_sent++;
      mk = 0;
    end else begin
      mk++;
    end
  endtask

  // One cycle of stimulus, applied at the falling edge
  task automatic drive(input bit v, input int coef, input bit qw, input int qa, input int qd,
                       output bit acc);
    @(negedge sys_clk);
    in_valid  = v;
    in_coef   = coef[COEF_W-1:0];
    q_wr_en   = qw;
    q_wr_addr = qa[5:0];
    q_wr_data = qd[Q_W-1:0];
    #1;
    acc = v && in_ready;
    if (acc) model_accept(coef);
    if (qw && sys_rst) qm[qa] = qd;
  endtask

  task automatic q_write(input int a, input int d);
    bit acc;
    drive(1'b0, 0, 1'b1, a, d, acc);
  endtask

  task automatic send_block(input int n, input int gap_pct, input bit rand_q);
    int i, guard, qa, qd;
    bit acc, qw;
    i = 0;
    guard = 0;
    while (i < n && guard < 4000) begin
      qw = 0; qa = 0; qd = 0;
      if (rand_q && $urandom_range(99) < 20) begin
        qw = 1;
        qa = ($urandom_range(1) == 0) ? i : int'($urandom_range(63));
        qd = int'($urandom_range(255));
      end
      if (int'($urandom_range(99)) < gap_pct) drive(1'b0, 0, qw, qa, qd, acc);
      else begin
        drive(1'b1, blk[i], qw, qa, qd, acc);
        if (acc) i++;
      end
      guard++;
    end
    n_chk++;
    if (i < n) begin
      n_fail++;
      $display("FAIL send_block: accepted %0d, expected %0d", i, n);
    end
  endtask

  task automatic finish_block(input bit hold_hi, input int low_cycles);
    int t, tgt;
    t = 0;
    tgt = blocks_sent;
    @(negedge sys_clk);
    in_valid = 1'b0;
    q_wr_en  = 1'b0;
    while (n_starts < tgt && t < 10) begin
      @(negedge sys_clk);
      t++;
    end
    chk("start_seen", n_starts, tgt);
    if (hold_hi) begin
      repeat (3) begin
        @(negedge sys_clk);
        chk("wait_ready_done_held", in_ready, 0);
      end
      idct_done = 1'b0;
    end
    repeat (low_cycles) begin
      @(negedge sys_clk);
      chk("wait_ready", in_ready, 0);
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("hold_x[%0d][%0d]", r, c), x[r][c], mx[r][c]);
    @(negedge sys_clk);
    idct_done = 1'b1;
    #1;
    chk("ready_at_done_edge", in_ready, 0);
    @(negedge sys_clk);
    chk("ready_after_done", in_ready, 1);
    idct_done = 1'b0;
  endtask

  task automatic rand_blk();
    for (int i = 0; i < 64; i++)
      blk[i] = ($urandom_range(3) == 0) ? int'($urandom_range(4095)) - 2048
                                        : int'($urandom_range(63)) - 32;
  endtask

  task automatic zero_blk();
    for (int i = 0; i < 64; i++) blk[i] = 0;
  endtask

  // Monitor: compare each presented matrix against the scoreboard head
  initial begin
    bit prev;
    int ev, ec;
    bit es;
    prev = 0;
    forever begin
      @(negedge sys_clk);
      if (start === 1'b1) begin
        chk("start_single_cycle", prev, 0);
        if (exp_sat.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL start_unexpected: got start=1, expected no pending block");
        end else begin
          for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
              ev = exp_vals.pop_front();
              chk($sformatf("x[%0d][%0d]", r, c), x[r][c], ev);
            end
          es = exp_sat.pop_front();
          ec = exp_cyc.pop_front();
          chk("sat_flag", sat_flag, es);
          chk("start_latency", cyc, ec);
        end
        n_starts++;
      end
      prev = start;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int sb;
    build_zz();
    reset_model();

    // Reset state
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_start", start, 0);
    chk("rst_sat", sat_flag, 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("rst_x[%0d][%0d]", r, c), x[r][c], 0);
    sys_rst = 1'b1;
    #1;
    chk("ready_after_rst", in_ready, 1);

    // DC only
    zero_blk();
    blk[0] = 1024;
    send_block(64, 0, 0);
    finish_block(0, 5);
    chk("t1_x00", x[0][0], 1024);

    // Zigzag ordering
    for (int i = 0; i < 64; i++) blk[i] = i + 1;
    send_block(64, 30, 0);
    finish_block(0, 3);
    chk("t2_x01", x[0][1], 2);
    chk("t2_x10", x[1][0], 3);
    chk("t2_x20", x[2][0], 4);
    chk("t2_x07", x[0][7], 29);
    chk("t2_x70", x[7][0], 36);
    chk("t2_x77", x[7][7], 64);

    // Dequantization, including a zero quant entry
    q_write(0, 16);
    q_write(4, 3);
    q_write(1, 0);
    zero_blk();
    blk[0] = -5;
    blk[4] = 7;
    blk[1] = 100;
    send_block(64, 10, 0);
    finish_block(0, 2);
    chk("t3_x00", x[0][0], -80);
    chk("t3_x11", x[1][1], 21);
    chk("t3_x01", x[0][1], 0);
    chk("t3_sat", sat_flag, 0);

    // Clipping and sticky flag reload per block
    q_write(0, 255);
    zero_blk();
    blk[0] = 2047;
    send_block(64, 0, 0);
    finish_block(0, 2);
    chk("t4_pos_clip", x[0][0], 32767);
    chk("t4_pos_sat", sat_flag, 1);
    blk[0] = -2048;
    send_block(64, 0, 0);
    finish_block(0, 2);
    chk("t4_neg_clip", x[0][0], -32768);
    chk("t4_neg_sat", sat_flag, 1);
    blk[0] = 1;
    send_block(64, 0, 0);
    finish_block(0, 2);
    chk("t4_noclip_x00", x[0][0], 255);
    chk("t4_noclip_sat", sat_flag, 0);

    // Handshake: done held high across ISSUE, then low, then rising
    rand_blk();
    idct_done = 1'b1;
    send_block(64, 40, 0);
    finish_block(1, 20);

    // Random blocks with random quant writes, some hitting the current index
    repeat (4) begin
      rand_blk();
      send_block(64, 25, 1);
      finish_block(0, int'($urandom_range(1, 6)));
    end

    // Reset mid-block
    rand_blk();
    send_block(30, 20, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    chk("t6_ready_in_rst", in_ready, 0);
    @(negedge sys_clk);
    chk("t6_start", start, 0);
    chk("t6_sat", sat_flag, 0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        chk($sformatf("t6_x[%0d][%0d]", r, c), x[r][c], 0);
    sys_rst = 1'b1;
    in_valid = 1'b0;
    reset_model();
    #1;
    chk("t6_ready_after_rst", in_ready, 1);
    sb = n_starts;
    rand_blk();
    send_block(64, 20, 0);
    finish_block(0, 3);
    chk("t6_single_start", n_starts, sb + 1);

    repeat (3) @(negedge sys_clk);
    chk("scoreboard_empty", exp_sat.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
